prog_loader: RTL and testbench
==============================

# prog_loader

Program-memory writer for the 4-bit fetch/execute datapath. Accepts instruction/operand nibble pairs over a valid/ready stream, packs each pair into one program byte ({instr, oprnd}), and writes the bytes to consecutive addresses of the 4096×8 program memory starting at a loaded base address. It is the write-side counterpart of the program counter / ROM / fetch path, used to fill program memory before the program counter starts.

## Interface
- ADDR_W, 12, program-memory address width; depth is 2^ADDR_W bytes
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces the reset state immediately
- start  in  1  begin a load; sampled only in IDLE
- abort  in  1  cancel an in-progress load; no done pulse
- base_addr  in  ADDR_W  first write address; latched on accepted start
- length  in  ADDR_W+1  number of bytes to write, 0..2^ADDR_W; latched on accepted start
- in_valid  in  1  in_instr/in_oprnd valid
- in_instr  in  4  instruction nibble; becomes byte bits [7:4]
- in_oprnd  in  4  operand nibble; becomes byte bits [3:0]
- in_ready  out  1  loader accepts a pair this cycle
- wr_en  out  1  program-memory write strobe, one cycle per byte
- wr_addr  out  ADDR_W  write address
- wr_data  out  8  write data {instr, oprnd}
- busy  out  1  high in LOAD and DONE
- done  out  1  one-cycle pulse on completion
- wrapped  out  1  sticky; address wrapped from 2^ADDR_W−1 to 0 during this load
- checksum  out  8  only with PL_CHECKSUM_EN (see Configuration)

## Operation
- States: IDLE, LOAD, DONE. Reset: IDLE; in_ready, wr_en, busy, done, wrapped = 0; wr_addr, wr_data, internal address, remaining count = 0.
- IDLE: start=1 → latch base_addr into address counter, length into remaining, clear wrapped (and checksum). If length≠0 → LOAD, else → DONE. start outside IDLE is ignored.
- LOAD: in_ready=1 (combinational on state). Transfer = in_valid & in_ready on a rising edge. On transfer: register wr_en=1, wr_addr=address, wr_data={in_instr,in_oprnd}; address += 1 modulo 2^ADDR_W; remaining −= 1. If address was 2^ADDR_W−1, set wrapped. If remaining was 1 → DONE.
- No transfer in a cycle → wr_en=0 next cycle; in_valid may idle indefinitely.
- DONE: done=1 for exactly this cycle; in_ready=0; next state IDLE.
- abort=1 in LOAD or DONE → IDLE next edge, no done pulse; a transfer coinciding with abort is dropped (no write). abort has priority over transfer and start.
- Length 2^ADDR_W: full memory written once; wrapped sets only if base_addr≠0.
- reset mid-load: immediate return to reset state; any pending write strobe is cancelled.

## Timing
- start sampled at edge N → busy, in_ready high from N (after the edge) on.
- Transfer at edge k → wr_en/wr_addr/wr_data valid in cycle after k (1-cycle latency); back-to-back transfers give back-to-back writes, throughput 1 byte/cycle.
- Last transfer at edge k → cycle after k: state DONE, done=1, last wr_en=1, in_ready=0; edge k+1 → IDLE, busy=0.
- length=0: start at edge N → DONE cycle after N, done=1, no wr_en; IDLE after N+1.
- Earliest new start: cycle after DONE (in IDLE).

## Configuration
- PL_CHECKSUM_EN defined: checksum port present; 8-bit modulo-256 sum of all wr_data written in the current load; cleared to 0 on accepted start and on reset; updated in the same cycle wr_en is asserted (includes current byte); holds after done until next start.
- Not defined: checksum port and adder absent; all other behaviour identical.

## Test plan
- Reset then start, base_addr=0x000, length=3, pairs (1,2),(3,4),(F,0) every cycle → writes 0x12@0x000, 0x34@0x001, 0xF0@0x002 on consecutive cycles; done pulse with last write; checksum=0x36.
- base_addr=0xFFE, length=4 → writes at 0xFFE, 0xFFF, 0x000, 0x001; wrapped=1 after third write, stays 1 until next start.
- length=0 → done one cycle after start, no wr_en, busy high for one cycle.
- length=2 with in_valid gapped (1,0,0,1) → exactly two writes, each one cycle after its transfer; in_ready high throughout LOAD.
- abort asserted together with second transfer of length=5 → only first byte written, no done, IDLE next cycle; start during LOAD ignored.
- reset asserted mid-load (asynchronously, between edges) → all outputs 0 immediately; subsequent start at base 0x100 loads normally.

Source files
------------

// File: rtl/prog_loader.sv
// Program-memory writer: packs {instr, oprnd} nibble pairs into bytes and writes
// them to consecutive addresses from a base. Optional checksum port: PL_CHECKSUM_EN.
module prog_loader #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              in_valid,
  input  logic [3:0]        in_instr,
  input  logic [3:0]        in_oprnd,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
`ifdef PL_CHECKSUM_EN
  output logic [7:0]        checksum,
`endif
  output logic              wrapped
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W:0]     remaining_q, remaining_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                wrapped_q, wrapped_d;
  logic [7:0]          csum_q, csum_d;
  logic                xfer_s;
  logic [7:0]          byte_s;

  assign xfer_s = in_valid && (state_q == S_LOAD);
  assign byte_s = {in_instr, in_oprnd};

  // Next-state and datapath computation; abort outranks both transfer and start.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wrapped_d   = wrapped_q;
    csum_d      = csum_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d      = base_addr;
          remaining_d = length;
          wrapped_d   = 1'b0;
          csum_d      = 8'd0;
          if (length == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (xfer_s) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = addr_q;
          wr_data_d   = byte_s;
          addr_d      = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
          remaining_d = remaining_q - {{ADDR_W{1'b0}}, 1'b1};
          csum_d      = csum_q + byte_s;
          // Only a wrap that is followed by another write counts, so a full
          // load from address 0 does not flag itself as wrapped.
          if ((addr_q == {ADDR_W{1'b1}}) && (remaining_q != {{ADDR_W{1'b0}}, 1'b1})) begin
            wrapped_d = 1'b1;
          end else begin
            wrapped_d = wrapped_q;
          end
          if (remaining_q == {{ADDR_W{1'b0}}, 1'b1}) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'd0;
      wrapped_q   <= 1'b0;
      csum_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wrapped_q   <= wrapped_d;
      csum_q      <= csum_d;
    end
  end

  assign in_ready = (state_q == S_LOAD);
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wrapped  = wrapped_q;
`ifdef PL_CHECKSUM_EN
  assign checksum = csum_q;
`else
  logic unused_csum_s;
  assign unused_csum_s = ^csum_q;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and randomized loads checked
// against a transaction-level model (expected byte list per load).
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [11:0] base_addr = 12'd0;
  logic [12:0] length = 13'd0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_instr = 4'd0;
  logic [3:0]  in_oprnd = 4'd0;
  logic        in_ready, wr_en, busy, done, wrapped;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
`ifdef PL_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] fixed_data [0:2];

  prog_loader dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_instr(in_instr), .in_oprnd(in_oprnd),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done),
`ifdef PL_CHECKSUM_EN
    .checksum(checksum),
`endif
    .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete load. pat!=0 gives a fixed valid pattern (bit i = cycle i),
  // otherwise valid is random with probability vprob percent.
  task automatic do_load(input logic [11:0] b, input logic [12:0] len,
                         input int vprob, input logic [31:0] pat, input bit use_fixed);
    int sent = 0;
    int cyc = 0;
    bit v;
    logic [7:0] bt;
    logic [7:0] sum = 8'd0;
    logic [11:0] ea;
    bit exp_wrap;
    exp_wrap = (int'(b) + int'(len)) > 4096;
    start = 1'b1; base_addr = b; length = len; in_valid = 1'b0;
    step();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("wrapped_cleared", wrapped, 0);
`ifdef PL_CHECKSUM_EN
    chk("csum_cleared", checksum, 0);
`endif
    if (len == 13'd0) begin
      chk("len0_done", done, 1);
      chk("len0_wr_en", wr_en, 0);
      chk("len0_ready", in_ready, 0);
      step();
      chk("len0_idle_busy", busy, 0);
      chk("len0_idle_done", done, 0);
      return;
    end
    while (sent < int'(len) && cyc < 20000) begin
      chk("ready_in_load", in_ready, 1);
      chk("no_early_done", done, 0);
      v = (pat != 32'd0) ? pat[cyc % 32] : ($urandom_range(0, 99) < vprob);
      if (use_fixed && sent < 3) bt = fixed_data[sent];
      else bt = 8'($urandom_range(0, 255));
      in_valid = v; in_instr = bt[7:4]; in_oprnd = bt[3:0];
      step();
      cyc++;
      chk("wr_en", wr_en, v);
      if (v) begin
        ea = b + 12'(sent);
        chk("wr_addr", wr_addr, ea);
        chk("wr_data", wr_data, bt);
        sum = sum + bt;
        if (int'(b) + sent >= 4096) chk("wrapped_after_wrap", wrapped, 1);
        sent++;
        chk("done_with_last", done, (sent == int'(len)) ? 1 : 0);
      end
    end
    if (sent < int'(len)) begin
      chk("load_timeout", 0, 1);
      return;
    end
    in_valid = 1'b0;
    chk("done_ready", in_ready, 0);
    chk("done_busy", busy, 1);
    chk("wrapped_final", wrapped, exp_wrap);
`ifdef PL_CHECKSUM_EN
    chk("checksum", checksum, sum);
`endif
    step();
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_wr_en", wr_en, 0);
    chk("wrapped_sticky", wrapped, exp_wrap);
`ifdef PL_CHECKSUM_EN
    chk("checksum_hold", checksum, sum);
`endif
  endtask

  initial begin
    fixed_data[0] = 8'h12; fixed_data[1] = 8'h34; fixed_data[2] = 8'hF0;
    #12;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_wrapped", wrapped, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Basic three-byte load; sum 0x12+0x34+0xF0 = 0x36.
    do_load(12'h000, 13'd3, 100, 32'd0, 1'b1);
    // Wrap across the top of memory.
    do_load(12'hFFE, 13'd4, 100, 32'd0, 1'b0);
    // Zero length.
    do_load(12'h123, 13'd0, 100, 32'd0, 1'b0);
    // Gapped valid 1,0,0,1.
    do_load(12'h050, 13'd2, 100, 32'h9, 1'b0);
    // Single byte at the last address: no wrap.
    do_load(12'hFFF, 13'd1, 100, 32'd0, 1'b0);

    // Abort together with the second transfer; start during LOAD ignored.
    start = 1'b1; base_addr = 12'h200; length = 13'd5;
    step();
    start = 1'b1; base_addr = 12'h7A0; in_valid = 1'b1; in_instr = 4'hA; in_oprnd = 4'h5;
    step();
    start = 1'b0;
    chk("abort_first_wr", wr_en, 1);
    chk("abort_first_addr", wr_addr, 12'h200);
    chk("abort_first_data", wr_data, 8'hA5);
    abort = 1'b1; in_instr = 4'h3; in_oprnd = 4'hC;
    step();
    abort = 1'b0; in_valid = 1'b0;
    chk("abort_no_wr", wr_en, 0);
    chk("abort_no_done", done, 0);
    chk("abort_idle", busy, 0);
    chk("abort_data_hold", wr_data, 8'hA5);
    step();
    chk("abort_still_no_done", done, 0);

    // Asynchronous reset between edges mid-load.
    start = 1'b1; base_addr = 12'h300; length = 13'd6;
    step();
    start = 1'b0; in_valid = 1'b1; in_instr = 4'h9; in_oprnd = 4'h9;
    step();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_wr_en", wr_en, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_addr", wr_addr, 0);
    chk("mid_rst_data", wr_data, 0);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step();
    do_load(12'h100, 13'd4, 100, 32'd0, 1'b0);

    // Randomized loads, including some near the top of memory.
    for (int i = 0; i < 10; i++) begin
      logic [11:0] rb;
      logic [12:0] rl;
      rb = (i % 3 == 0) ? 12'(4096 - $urandom_range(1, 8)) : 12'($urandom_range(0, 4095));
      rl = 13'($urandom_range(0, 40));
      do_load(rb, rl, $urandom_range(30, 100), 32'd0, 1'b0);
    end

    // Whole memory from address 0 (no wrap), then from nonzero base (wrap).
    do_load(12'h000, 13'd4096, 100, 32'd0, 1'b0);
    do_load(12'h800, 13'd4096, 100, 32'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
